// File: rtl/spad_io_ctrl.sv
// spad_io_ctrl: fill/drain sequencer between a PE scratchpad and NoC streams.
// Fill writes an input stream to consecutive SPad addresses. Drain reads
// consecutive addresses into a 2-entry output FIFO that absorbs the
// SPad's 1-cycle read latency.
// Optional macro SPAD_IO_PSUM_CLEAR_EN: each drain read also zeroes the
// location it reads.
module spad_io_ctrl #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_fill,
  input  logic                     start_drain,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH:0]   count,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     spad_read_req,
  output logic [ADDR_BITWIDTH-1:0] spad_r_addr,
  output logic                     spad_write_en,
  output logic [ADDR_BITWIDTH-1:0] spad_w_addr,
  output logic [DATA_BITWIDTH-1:0] spad_w_data,
  input  logic [DATA_BITWIDTH-1:0] spad_r_data
);

  localparam int unsigned CNT_W = ADDR_BITWIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN, ST_DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] base_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         idx_q;    // words written (fill) or reads issued (drain)
  logic [CNT_W-1:0]         ocnt_q;   // output handshakes completed (drain)
  logic                     rd_pend_q;
  logic [DATA_BITWIDTH-1:0] fifo_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               occ_q;

  logic [ADDR_BITWIDTH-1:0] cur_addr;
  logic                     rd_issue, fill_hs, out_hs, fifo_push, fifo_pop;
  logic                     start_any;

  // Shared datapath decode used by both the FSM and the output logic.
  always_comb begin
    start_any = start_fill | start_drain;
    cur_addr  = ADDR_BITWIDTH'(base_q + idx_q[ADDR_BITWIDTH-1:0]);
    fill_hs   = (state_q == ST_FILL) && in_valid;
    rd_issue  = (state_q == ST_DRAIN)
             && ((3'(occ_q) + 3'(rd_pend_q)) < 3'd2)
             && (idx_q < count_q);
    out_hs    = out_valid && out_ready;
    // Arriving read data bypasses the FIFO when it is empty and consumed now.
    fifo_push = rd_pend_q && !((occ_q == 2'd0) && out_ready);
    fifo_pop  = out_hs && (occ_q != 2'd0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a simultaneous fill and drain start resolves to fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_any) begin
          if (count == '0)      state_d = ST_DONE;
          else if (start_fill)  state_d = ST_FILL;
          else                  state_d = ST_DRAIN;
        end
      end
      ST_FILL: begin
        if (fill_hs && ((idx_q + CNT_W'(1)) == count_q)) state_d = ST_DONE;
      end
      ST_DRAIN: begin
        if (out_hs && ((ocnt_q + CNT_W'(1)) == count_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; SPad controls are held at zero when not in use.
  always_comb begin
    busy          = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    done          = (state_q == ST_DONE);
    in_ready      = (state_q == ST_FILL);
    out_valid     = (state_q == ST_DRAIN) && ((occ_q != 2'd0) || rd_pend_q);
    out_data      = '0;
    spad_read_req = 1'b0;
    spad_r_addr   = '0;
    spad_write_en = 1'b0;
    spad_w_addr   = '0;
    spad_w_data   = '0;
    if (occ_q != 2'd0) out_data = fifo_q[rd_ptr_q];
    else if (rd_pend_q) out_data = spad_r_data;
    if (fill_hs) begin
      spad_write_en = 1'b1;
      spad_w_addr   = cur_addr;
      spad_w_data   = in_data;
    end
    if (rd_issue) begin
      spad_read_req = 1'b1;
      spad_r_addr   = cur_addr;
`ifdef SPAD_IO_PSUM_CLEAR_EN
      spad_write_en = 1'b1;
      spad_w_addr   = cur_addr;
      spad_w_data   = '0;
`endif
    end
  end

  // Command registers, counters and the 2-entry drain FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      ocnt_q    <= '0;
      rd_pend_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= '0;
    end else begin
      rd_pend_q <= rd_issue;
      if ((state_q == ST_IDLE) && start_any) begin
        base_q   <= base_addr;
        count_q  <= count;
        idx_q    <= '0;
        ocnt_q   <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        occ_q    <= '0;
      end else begin
        if (fill_hs || rd_issue) idx_q <= idx_q + CNT_W'(1);
        if (out_hs) ocnt_q <= ocnt_q + CNT_W'(1);
        if (fifo_push) begin
          fifo_q[wr_ptr_q] <= spad_r_data;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
        case ({fifo_push, fifo_pop})
          2'b10:   occ_q <= occ_q + 2'd1;
          2'b01:   occ_q <= occ_q - 2'd1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spad_io_ctrl.sv
// Testbench for spad_io_ctrl: table of fill/drain commands with randomized
// stream timing, checked against a reference SPad image and expected queues,
// plus a hand-written dual-start / mid-fill reset sequence.
module tb_spad_io_ctrl;

  logic        clk;
  logic        reset;
  logic        start_fill, start_drain;
  logic [8:0]  base_addr;
  logic [9:0]  count;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        spad_read_req;
  logic [8:0]  spad_r_addr;
  logic        spad_write_en;
  logic [8:0]  spad_w_addr;
  logic [15:0] spad_w_data;
  logic [15:0] spad_r_data;

  spad_io_ctrl #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(9)) dut (
    .clk(clk), .reset(reset),
    .start_fill(start_fill), .start_drain(start_drain),
    .base_addr(base_addr), .count(count),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spad_read_req(spad_read_req), .spad_r_addr(spad_r_addr),
    .spad_write_en(spad_write_en), .spad_w_addr(spad_w_addr),
    .spad_w_data(spad_w_data), .spad_r_data(spad_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SPad: registered read, filler value when no read is issued.
  logic [15:0] spad_mem [512];
  always @(posedge clk) begin
    if (spad_read_req) spad_r_data <= spad_mem[spad_r_addr];
    else               spad_r_data <= 16'hDEAD;
    if (spad_write_en) spad_mem[spad_w_addr] <= spad_w_data;
  end

  // Reference image of what the SPad should contain.
  logic [15:0] ref_mem [512];

  int checks   = 0;
  int failures = 0;
  int cur_id   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cmd %0d) actual=%0d required=%0d", name, cur_id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_in_ready"},  32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data), 0);
    chk({tag, "_rd_req"},    32'(spad_read_req), 0);
    chk({tag, "_r_addr"},    32'(spad_r_addr), 0);
    chk({tag, "_we"},        32'(spad_write_en), 0);
    chk({tag, "_w_addr"},    32'(spad_w_addr), 0);
    chk({tag, "_w_data"},    32'(spad_w_data), 0);
  endtask

  // vmode: 0 = always valid/ready, 1 = random, 2 = ready pattern 1,0,0,1,0,0,...
  // d0/dstep: nonzero d0 gives fill data d0 + i*dstep, else random words.
  // exp_done / exp_first: cycle (relative to start) of done / first out_valid, -1 = unchecked.
  task automatic run_cmd(input bit is_fill, input int base, input int cnt, input int vmode,
                         input int d0, input int dstep, input int exp_done, input int exp_first);
    logic [15:0] wdata [$];
    logic [15:0] exp_q [$];
    int widx, ridx, hs, first, done_at, k;
    bit fin, exp_d;
    widx = 0; ridx = 0; hs = 0; first = -1; done_at = -1; fin = 0;
    for (int i = 0; i < cnt; i++) begin
      if (is_fill) wdata.push_back((d0 != 0) ? 16'(d0 + i * dstep) : 16'($urandom));
      else         exp_q.push_back(ref_mem[(base + i) % 512]);
    end
    start_fill  = is_fill;
    start_drain = !is_fill;
    base_addr   = 9'(base);
    count       = 10'(cnt);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 0);
    tick();
    k = 1;
    while (!fin && k < 4000) begin
      // Starts while not idle must be ignored.
      start_fill  = ($urandom_range(0, 3) == 0);
      start_drain = ($urandom_range(0, 3) == 0);
      base_addr   = 9'($urandom);
      count       = 10'($urandom);
      if (is_fill) begin
        in_valid  = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data   = (widx < cnt) ? wdata[widx] : 16'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 16'($urandom);
        if (vmode == 0)      out_ready = 1'b1;
        else if (vmode == 2) out_ready = (((k - 1) % 3) == 0);
        else                 out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exp_d = is_fill ? (widx == cnt) : (hs == cnt);
      chk("done", 32'(done), 32'(exp_d));
      chk("busy", 32'(busy), 32'(!exp_d));
      if (is_fill) begin
        chk("fill_in_ready", 32'(in_ready), 32'(widx < cnt));
        chk("fill_out_valid", 32'(out_valid), 0);
        chk("fill_rd_req", 32'(spad_read_req), 0);
        chk("fill_we", 32'(spad_write_en), 32'(in_valid && (widx < cnt)));
        if (in_valid && (widx < cnt)) begin
          chk("fill_w_addr", 32'(spad_w_addr), (base + widx) % 512);
          chk("fill_w_data", 32'(spad_w_data), 32'(wdata[widx]));
          ref_mem[(base + widx) % 512] = wdata[widx];
          widx++;
        end
      end else begin
        chk("drain_in_ready", 32'(in_ready), 0);
        if (spad_read_req) begin
          chk("drain_r_addr", 32'(spad_r_addr), (base + ridx) % 512);
          ridx++;
          chk("drain_read_limit", 32'(ridx <= cnt), 1);
          chk("drain_outstanding", 32'((ridx - hs) <= 2), 1);
`ifdef SPAD_IO_PSUM_CLEAR_EN
          chk("clear_we", 32'(spad_write_en), 1);
          chk("clear_w_addr", 32'(spad_w_addr), 32'(spad_r_addr));
          chk("clear_w_data", 32'(spad_w_data), 0);
          ref_mem[spad_r_addr] = 16'h0000;
`else
          chk("drain_we", 32'(spad_write_en), 0);
`endif
        end else begin
          chk("drain_we_idle", 32'(spad_write_en), 0);
        end
        if (hs == cnt) chk("drain_valid_after_last", 32'(out_valid), 0);
        if (out_valid && first < 0) first = k;
        if (out_valid && out_ready && hs < cnt) begin
          chk("drain_data", 32'(out_data), 32'(exp_q[hs]));
          hs++;
        end
      end
      if (done || exp_d) begin
        fin = 1;
        done_at = k;
      end
      tick();
      k++;
    end
    if (!fin) chk("timeout", 0, 1);
    if (exp_done >= 0) chk("done_cycle", 32'(done_at), 32'(exp_done));
    if (exp_first >= 0) chk("first_valid_cycle", 32'(first), 32'(exp_first));
    start_fill = 0; start_drain = 0; in_valid = 0; out_ready = 0;
    @(negedge clk);
    check_idle("after_done");
    tick();
  endtask

  typedef struct {
    bit is_fill;
    int base;
    int cnt;
    int vmode;
    int d0;
    int dstep;
    int exp_done;
    int exp_first;
  } cmd_t;

  cmd_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1,   0,   4, 0, 11, 11,  5, -1};
    tbl[1]  = '{1'b1, 100,   3, 0,  7,  1,  4, -1};
    tbl[2]  = '{1'b0, 100,   3, 0,  0,  0,  5,  2};
    tbl[3]  = '{1'b1, 200,   5, 1,  0,  0, -1, -1};
    tbl[4]  = '{1'b0, 200,   5, 2,  0,  0, -1,  2};
    tbl[5]  = '{1'b1, 510,   4, 0,  0,  0,  5, -1};
    tbl[6]  = '{1'b1,  50,   0, 0,  0,  0,  1, -1};
    tbl[7]  = '{1'b0, 510,   4, 1,  0,  0, -1,  2};
    tbl[8]  = '{1'b0,  50,   0, 0,  0,  0,  1, -1};
    tbl[9]  = '{1'b1, 500,   5, 0,  0,  0,  6, -1};
    tbl[10] = '{1'b0, 500,   5, 0,  0,  0,  7,  2};
    tbl[11] = '{1'b0, 500,   5, 0,  0,  0,  7,  2};
    tbl[12] = '{1'b1, 300, 512, 1,  0,  0, -1, -1};
    tbl[13] = '{1'b0, 300, 512, 1,  0,  0, -1,  2};

    reset = 1; start_fill = 0; start_drain = 0; base_addr = 0; count = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    tick(); tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    reset = 0;
    @(negedge clk);
    check_idle("post_reset");
    tick();

    for (int i = 0; i < 14; i++) begin
      cur_id = i;
      run_cmd(tbl[i].is_fill, tbl[i].base, tbl[i].cnt, tbl[i].vmode,
              tbl[i].d0, tbl[i].dstep, tbl[i].exp_done, tbl[i].exp_first);
    end

    // Simultaneous starts: fill wins. Then reset after two words.
    cur_id = 100;
    start_fill = 1; start_drain = 1; base_addr = 9'd20; count = 10'd4;
    tick();
    start_fill = 0; start_drain = 0; in_valid = 1; in_data = 16'h00A1;
    @(negedge clk);
    chk("dual_in_ready", 32'(in_ready), 1);
    chk("dual_rd_req", 32'(spad_read_req), 0);
    chk("dual_we", 32'(spad_write_en), 1);
    chk("dual_w_addr0", 32'(spad_w_addr), 20);
    chk("dual_w_data0", 32'(spad_w_data), 32'h00A1);
    ref_mem[20] = 16'h00A1;
    tick();
    in_data = 16'h00A2;
    @(negedge clk);
    chk("dual_w_addr1", 32'(spad_w_addr), 21);
    chk("dual_w_data1", 32'(spad_w_data), 32'h00A2);
    ref_mem[21] = 16'h00A2;
    tick();
    in_valid = 0; reset = 1;
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 1);
    tick();
    reset = 0;
    @(negedge clk);
    check_idle("abort");
    tick();
    @(negedge clk);
    check_idle("abort_no_done");
    tick();
    cur_id = 101;
    run_cmd(1'b0, 20, 2, 0, 0, 0, 4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
